// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial subtractor that sequences one full-subtractor cell over WIDTH bits, LSB first
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int RW = WIDTH > 1 ? WIDTH - 1 : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d, diff_n;
  logic [RW-1:0]    r_q, r_d;
  logic [RW:0]      r_w;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d, brw_n, d_bit, busy_q, busy_d, done_q, done_d, bout_q, bout_d;
  logic             load, last, fin, run;
  // The result register only keeps the first WIDTH-1 bits; the final bit is merged straight into diff.
  always_comb begin
    run     = state_q == RUN;
    d_bit   = a_q[0] ^ b_q[0] ^ brw_q;
    brw_n   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
    r_w     = {d_bit, r_q};
    diff_n  = WIDTH'(r_w >> (RW + 1 - WIDTH));
    last    = cnt_q == CW'(WIDTH - 1);
    load    = start && !run;
    fin     = run && last;
    state_d = load ? RUN : run ? (last ? DONE : RUN) : IDLE;
    a_d     = load ? a : run ? a_q >> 1 : a_q;
    b_d     = load ? b : run ? b_q >> 1 : b_q;
    brw_d   = load ? bin : run ? brw_n : brw_q;
    cnt_d   = load ? '0 : run ? cnt_q + CW'(1) : cnt_q;
    r_d     = run ? r_w[RW:1] : r_q;
    diff_d  = fin ? diff_n : diff_q;
    bout_d  = fin ? brw_n : bout_q;
    busy_d  = state_d == RUN;
    done_d  = fin;
  end
  // State, datapath and registered handshake outputs; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
endmodule
